// File: rtl/ff_piso_serializer_pkg.sv
// Shared constants for the parallel-in/serial-out serializer and its bit counter.
// The default word length matches the 4-bit downstream serial register.
package ff_piso_serializer_pkg;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_SHIFT = 1'b1;

    localparam int PISO_WIDTH = 4;

    // Bits needed to hold values 0 .. value-1; never less than one bit.
    function automatic int clog2(input int value);
        int bits;
        int v;
        bits = 0;
        v = value - 1;
        while (v > 0) begin
            bits = bits + 1;
            v = v >> 1;
        end
        if (bits == 0) begin
            bits = 1;
        end
        return bits;
    endfunction

endpackage

// File: rtl/ff_bit_counter.sv
// Up-counter of emitted bits with synchronous clear and a terminal flag at WIDTH.
// Count updates one edge after enable; terminal is decoded from the registered count.
module ff_bit_counter
    import ff_piso_serializer_pkg::*;
#(
    parameter int WIDTH = PISO_WIDTH,
    parameter int CW    = clog2(WIDTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clear,
    input  logic          enable,
    output logic [CW-1:0] count,
    output logic          terminal
);

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + CW'(1);
        end
    end

    assign terminal = (count == CW'(WIDTH));

endmodule

// File: rtl/ff_piso_serializer.sv
// Loads one WIDTH-bit word via valid/ready and shifts it out one bit per clock, then pulses frame_done.
// Bit k is valid k+1 cycles after accept; load_ready is low for the WIDTH bit cycles and high again on frame_done.
module ff_piso_serializer
    import ff_piso_serializer_pkg::*;
#(
    parameter int WIDTH     = PISO_WIDTH,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] data_in,
    output logic             serial_out,
    output logic             serial_valid,
    output logic             frame_done,
    output logic             busy
);

    localparam int CW = clog2(WIDTH + 1);

    logic [0:0]       state;
    logic [WIDTH-1:0] shreg;
    logic [WIDTH-1:0] shreg_next;
    logic [CW-1:0]    cnt;
    logic             cnt_tc;
    logic             cnt_clear;
    logic             cnt_en;
    logic             accept;
    logic             shifting;

    function automatic logic first_bit(input logic [WIDTH-1:0] w);
        return MSB_FIRST ? w[WIDTH-1] : w[0];
    endfunction

    assign accept    = (state == ST_IDLE) && load_valid && load_ready;
    assign shifting  = (state == ST_SHIFT) && (cnt < CW'(WIDTH));
    assign cnt_clear = (state == ST_SHIFT) && cnt_tc;
    assign cnt_en    = accept || shifting;

    // Rotate rather than zero-fill: only WIDTH bits ever leave, so the wrapped bits are never seen.
    assign shreg_next = MSB_FIRST ? {shreg[WIDTH-2:0], shreg[WIDTH-1]}
                                  : {shreg[0], shreg[WIDTH-1:1]};

    ff_bit_counter #(
        .WIDTH (WIDTH),
        .CW    (CW)
    ) u_bit_counter (
        .clk      (clk),
        .rst      (rst),
        .clear    (cnt_clear),
        .enable   (cnt_en),
        .count    (cnt),
        .terminal (cnt_tc)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_IDLE;
            shreg        <= '0;
            load_ready   <= 1'b0;
            serial_out   <= 1'b0;
            serial_valid <= 1'b0;
            frame_done   <= 1'b0;
            busy         <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    frame_done <= 1'b0;
                    load_ready <= 1'b1;
                    if (accept) begin
                        shreg        <= data_in;
                        serial_out   <= first_bit(data_in);
                        serial_valid <= 1'b1;
                        busy         <= 1'b1;
                        load_ready   <= 1'b0;
                        state        <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    if (cnt_tc) begin
                        serial_out   <= 1'b0;
                        serial_valid <= 1'b0;
                        frame_done   <= 1'b1;
                        busy         <= 1'b0;
                        load_ready   <= 1'b1;
                        state        <= ST_IDLE;
                    end else if (shifting) begin
                        shreg      <= shreg_next;
                        serial_out <= first_bit(shreg_next);
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // The downstream register relies on a clean zero between frames.
    a_out_quiet : assert property (@(posedge clk) disable iff (rst) !serial_valid |-> !serial_out);
    a_done_idle : assert property (@(posedge clk) disable iff (rst) frame_done |-> (!busy && load_ready));
    a_busy_vld  : assert property (@(posedge clk) disable iff (rst) busy == serial_valid);

endmodule
